// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard controller for the five-stage core. Lives beside the ID/EX
// pipeline register and produces the load-enable and flush (bubble) controls
// for the PC, IF/ID and ID/EX registers. It resolves:
//   * load-use hazards     (one bubble inserted into ID/EX, PC and IF/ID held)
//   * taken-branch redirect (IF/ID and ID/EX squashed, PC takes the target)
//   * multi-cycle multiply occupancy of EX (front end frozen, EX/MEM bubbled)
// and keeps a saturating count of cycles in which the PC was not written.
//
// Parameters
//   MUL_LAT          total cycles a multiply occupies EX (legal 2..16)
//
// Ports
//   clk              core clock, all state updates on the rising edge
//   reset            asynchronous, active-high; clears all state immediately
//   id_rs1/id_rs2    source register fields of the instruction in ID
//   id_uses_rs2      instruction in ID actually reads rs2
//   id_mul           instruction in ID is a multi-cycle multiply
//   ex_memread       instruction in EX is a load
//   ex_rd            destination register of the instruction in EX
//   ex_branch_taken  branch in EX resolved taken
//   stat_clr         synchronous clear of stall_cycles
//   pc_write         PC load enable
//   ifid_write       IF/ID load enable
//   ifid_flush       IF/ID loads a NOP
//   idex_write       ID/EX load enable
//   idex_flush       ID/EX loads zero control fields
//   exmem_bubble     EX/MEM loads zero control fields
//   busy             a multiply is occupying EX
//   stall_cycles     saturating count of cycles with pc_write = 0
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int MUL_LAT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs2,
    input  logic        id_mul,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rd,
    input  logic        ex_branch_taken,
    input  logic        stat_clr,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        idex_write,
    output logic        idex_flush,
    output logic        exmem_bubble,
    output logic        busy,
    output logic [15:0] stall_cycles
);

    typedef enum logic {
        RUN = 1'b0,
        MUL = 1'b1
    } state_t;

    // Cycles remaining after the first EX cycle of a multiply. The release
    // cycle is the one where the counter has reached zero.
    localparam logic [3:0] CNT_LOAD = 4'(MUL_LAT - 1);

    localparam logic [15:0] STALL_MAX = 16'hFFFF;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] stall_q, stall_d;

    logic        load_use;

    // Unforced control values; reset overrides them below.
    logic        pc_write_c;
    logic        ifid_write_c;
    logic        ifid_flush_c;
    logic        idex_write_c;
    logic        idex_flush_c;
    logic        exmem_bubble_c;
    logic        busy_c;

    // -------------------------------------------------------------------------
    // Load-use detection. x0 is hard-wired to zero, so a load targeting it can
    // never create a real dependency. rs2 only matters when ID really reads it.
    // -------------------------------------------------------------------------
    always_comb begin
        load_use = ex_memread
                 & (ex_rd != 5'd0)
                 & ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));
    end

    // -------------------------------------------------------------------------
    // Next-state and control outputs.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pc_write_c     = 1'b1;
        ifid_write_c   = 1'b1;
        ifid_flush_c   = 1'b0;
        idex_write_c   = 1'b1;
        idex_flush_c   = 1'b0;
        exmem_bubble_c = 1'b0;
        busy_c         = 1'b0;

        case (state_q)
            RUN: begin
                if (ex_branch_taken) begin
                    // Redirect wins: the instructions in IF and ID are on the
                    // wrong path, so any hazard they raise is irrelevant.
                    ifid_flush_c = 1'b1;
                    idex_flush_c = 1'b1;
                end else if (load_use) begin
                    // Hold PC and IF/ID, let a bubble into ID/EX. Next cycle
                    // the load is in MEM and forwarding covers the dependency.
                    pc_write_c   = 1'b0;
                    ifid_write_c = 1'b0;
                    idex_flush_c = 1'b1;
                end else if (id_mul) begin
                    // The multiply advances into EX on this edge.
                    state_d = MUL;
                    cnt_d   = CNT_LOAD;
                end
            end

            MUL: begin
                busy_c = 1'b1;
                if (cnt_q != 4'd0) begin
                    // EX still holds the multiply: freeze the front end and
                    // keep EX/MEM from capturing a partial result.
                    pc_write_c     = 1'b0;
                    ifid_write_c   = 1'b0;
                    idex_write_c   = 1'b0;
                    exmem_bubble_c = 1'b1;
                    cnt_d          = cnt_q - 4'd1;
                end else begin
                    // Release cycle: the result leaves EX on this edge and the
                    // instruction in ID enters EX. A second multiply in ID
                    // starts immediately with no gap.
                    if (id_mul) begin
                        cnt_d = CNT_LOAD;
                    end else begin
                        state_d = RUN;
                    end
                end
            end

            default: begin
                state_d = RUN;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Reset forces the pipeline into a safe state: nothing loads, the front
    // registers take NOPs/bubbles.
    // -------------------------------------------------------------------------
    always_comb begin
        if (reset) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            ifid_flush   = 1'b1;
            idex_write   = 1'b0;
            idex_flush   = 1'b1;
            exmem_bubble = 1'b1;
            busy         = 1'b0;
        end else begin
            pc_write     = pc_write_c;
            ifid_write   = ifid_write_c;
            ifid_flush   = ifid_flush_c;
            idex_write   = idex_write_c;
            idex_flush   = idex_flush_c;
            exmem_bubble = exmem_bubble_c;
            busy         = busy_c;
        end
    end

    // -------------------------------------------------------------------------
    // Stall-cycle counter: clear has priority, then saturating increment on
    // every cycle the PC does not advance.
    // -------------------------------------------------------------------------
    always_comb begin
        stall_d = stall_q;
        if (stat_clr) begin
            stall_d = 16'd0;
        end else if (!pc_write && (stall_q != STALL_MAX)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;

    // -------------------------------------------------------------------------
    // State registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
            stall_q <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Directed testbench for hazard_ctrl with MUL_LAT = 4. Inputs are applied just
// after each rising edge and outputs are sampled 2 time units later, well
// away from either clock edge. Expected values are hand-derived.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int MUL_LAT = 4;

    logic        clk;
    logic        reset;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_uses_rs2;
    logic        id_mul;
    logic        ex_memread;
    logic [4:0]  ex_rd;
    logic        ex_branch_taken;
    logic        stat_clr;
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_write;
    logic        idex_flush;
    logic        exmem_bubble;
    logic        busy;
    logic [15:0] stall_cycles;

    int n_checks = 0;
    int n_pass   = 0;

    hazard_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs2     (id_uses_rs2),
        .id_mul          (id_mul),
        .ex_memread      (ex_memread),
        .ex_rd           (ex_rd),
        .ex_branch_taken (ex_branch_taken),
        .stat_clr        (stat_clr),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_write      (idex_write),
        .idex_flush      (idex_flush),
        .exmem_bubble    (exmem_bubble),
        .busy            (busy),
        .stall_cycles    (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs1          = 5'd0;
        id_rs2          = 5'd0;
        id_uses_rs2     = 1'b0;
        id_mul          = 1'b0;
        ex_memread      = 1'b0;
        ex_rd           = 5'd0;
        ex_branch_taken = 1'b0;
        stat_clr        = 1'b0;
    endtask

    // Checks the full control vector {pc, ifid_w, ifid_f, idex_w, idex_f, bub, busy}.
    task automatic check_ctrl(input string tag, input logic [6:0] exp);
        check(tag, {25'd0, pc_write, ifid_write, ifid_flush, idex_write,
                    idex_flush, exmem_bubble, busy}, {25'd0, exp});
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;

        // Reset state: forced safe controls, counter clear.
        #3;
        check_ctrl("reset_ctrl", 7'b0010110);
        check("reset_stall", 32'(stall_cycles), 32'd0);
        $display("txn reset: ctrl=%b%b%b%b%b%b%b stall=%0d", pc_write, ifid_write,
                 ifid_flush, idex_write, idex_flush, exmem_bubble, busy, stall_cycles);

        // First active cycle: plain instruction flows.
        next_cycle();
        reset = 1'b0;
        #2;
        check_ctrl("plain_after_reset", 7'b1101000);
        $display("txn plain: pc_write=%b", pc_write);

        // Load-use on rs1.
        next_cycle();
        ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5;
        #2;
        check_ctrl("load_use_rs1", 7'b0001100);
        $display("txn load_use rs1: pc_write=%b idex_flush=%b", pc_write, idex_flush);

        // Load now in MEM: no hazard, one stall counted.
        next_cycle();
        idle_inputs();
        #2;
        check_ctrl("after_load_use", 7'b1101000);
        check("stall_after_lu", 32'(stall_cycles), 32'd1);
        $display("txn after load_use: stall=%0d", stall_cycles);

        // Load to x0 never stalls.
        next_cycle();
        ex_memread = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0;
        #2;
        check("x0_no_stall", 32'(pc_write), 32'd1);
        $display("txn load x0: pc_write=%b", pc_write);

        // rs2 match ignored when rs2 unused.
        next_cycle();
        ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd3; id_rs2 = 5'd5; id_uses_rs2 = 1'b0;
        #2;
        check("rs2_unused_no_stall", 32'(pc_write), 32'd1);
        $display("txn rs2 unused: pc_write=%b", pc_write);

        // Same, but rs2 used: stall.
        next_cycle();
        id_uses_rs2 = 1'b1;
        #2;
        check_ctrl("rs2_used_stall", 7'b0001100);
        $display("txn rs2 used: pc_write=%b", pc_write);

        // Branch beats load-use and mul.
        next_cycle();
        idle_inputs();
        ex_branch_taken = 1'b1; ex_memread = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_mul = 1'b1;
        #2;
        check_ctrl("branch_priority", 7'b1111100);
        check("stall_two", 32'(stall_cycles), 32'd2);
        $display("txn branch+lu+mul: ifid_flush=%b idex_flush=%b", ifid_flush, idex_flush);

        // Still in RUN afterwards.
        next_cycle();
        idle_inputs();
        #2;
        check_ctrl("after_branch_run", 7'b1101000);
        $display("txn after branch: busy=%b", busy);

        // Single multiply; a taken branch in a MUL cycle must not flush.
        for (int k = 0; k <= 5; k++) begin
            next_cycle();
            idle_inputs();
            id_mul = (k == 0);
            ex_branch_taken = (k == 2);
            #2;
            check("mul_busy", 32'(busy), 32'((k >= 1) && (k <= 4)));
            check("mul_bubble", 32'(exmem_bubble), 32'((k >= 1) && (k <= 3)));
            check("mul_pc_write", 32'(pc_write), 32'(!((k >= 1) && (k <= 3))));
            check("mul_flush", 32'({ifid_flush, idex_flush}), 32'd0);
            $display("txn mul k=%0d: busy=%b bubble=%b pc_write=%b", k, busy, exmem_bubble, pc_write);
        end
        check("stall_after_mul", 32'(stall_cycles), 32'd5);

        // Back-to-back multiplies: second issued in the release cycle.
        for (int k = 0; k <= 9; k++) begin
            next_cycle();
            idle_inputs();
            id_mul = (k == 0) || (k == 4);
            #2;
            check("b2b_busy", 32'(busy), 32'((k >= 1) && (k <= 8)));
            check("b2b_bubble", 32'(exmem_bubble),
                  32'(((k >= 1) && (k <= 3)) || ((k >= 5) && (k <= 7))));
            $display("txn b2b k=%0d: busy=%b bubble=%b", k, busy, exmem_bubble);
        end
        check("stall_after_b2b", 32'(stall_cycles), 32'd11);

        // Reset mid-multiply (cnt = 2).
        for (int k = 0; k <= 2; k++) begin
            next_cycle();
            idle_inputs();
            id_mul = (k == 0);
        end
        #1;
        check("pre_reset_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("reset_mid_busy", 32'(busy), 32'd0);
        check("reset_mid_stall", 32'(stall_cycles), 32'd0);
        check_ctrl("reset_mid_ctrl", 7'b0010110);
        $display("txn reset mid-mul: busy=%b stall=%0d", busy, stall_cycles);
        next_cycle();
        reset = 1'b0;
        idle_inputs();
        #2;
        check_ctrl("plain_after_reset2", 7'b1101000);
        $display("txn plain after reset: pc_write=%b busy=%b", pc_write, busy);

        // Saturation: hold a load-use hazard for 65534 cycles.
        next_cycle();
        ex_memread = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9;
        repeat (65534) next_cycle();
        #2;
        check("stall_fffe", 32'(stall_cycles), 32'h0000FFFE);
        $display("txn preload: stall=0x%0h", stall_cycles);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            #2;
            check("stall_sat", 32'(stall_cycles), 32'h0000FFFF);
            $display("txn saturate %0d: stall=0x%0h", i, stall_cycles);
        end

        // Clear wins over a simultaneous stall.
        next_cycle();
        stat_clr = 1'b1;
        #2;
        check("clr_cycle_pc_write", 32'(pc_write), 32'd0);
        next_cycle();
        stat_clr = 1'b0;
        idle_inputs();
        #2;
        check("stall_cleared", 32'(stall_cycles), 32'd0);
        $display("txn stat_clr: stall=%0d", stall_cycles);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage core. Sits beside the ID/EX pipeline register and drives the write-enable and flush (bubble) controls of the PC, IF/ID and ID/EX registers. Resolves load-use hazards, taken-branch redirects and multi-cycle multiply occupancy of EX, and keeps a saturating stall-cycle counter for performance tracking.

## Interface
- MUL_LAT, 4, total cycles a multiply occupies EX; legal range 2..16
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- id_rs1  in  5  rs1 field of the instruction in ID
- id_rs2  in  5  rs2 field of the instruction in ID
- id_uses_rs2  in  1  instruction in ID reads rs2 (R-type, store, branch)
- id_mul  in  1  instruction in ID is a multi-cycle multiply
- ex_memread  in  1  instruction in EX is a load (ID/EX M-control read bit)
- ex_rd  in  5  destination register of the instruction in EX
- ex_branch_taken  in  1  branch in EX resolved taken
- stat_clr  in  1  synchronous clear of stall_cycles
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID loads a NOP
- idex_write  out  1  ID/EX load enable
- idex_flush  out  1  ID/EX loads zero control fields (bubble)
- exmem_bubble  out  1  EX/MEM loads zero control fields
- busy  out  1  multiply occupying EX
- stall_cycles  out  16  saturating count of cycles with pc_write=0

## Operation
- State: RUN, MUL. Down-counter cnt (4 bits). Outputs combinational from state, cnt and inputs.
- load_use = ex_memread & (ex_rd != 0) & ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2))).
- RUN, priority order:
  - ex_branch_taken: pc_write=1, ifid_write=1, ifid_flush=1, idex_write=1, idex_flush=1; stay RUN (id_mul and load_use ignored).
  - load_use: pc_write=0, ifid_write=0, idex_write=1, idex_flush=1; stay RUN.
  - id_mul: all writes 1, no flushes; next MUL, cnt <= MUL_LAT-1.
  - otherwise: all writes 1, no flushes; stay RUN.
- MUL, cnt != 0: pc_write=0, ifid_write=0, idex_write=0, exmem_bubble=1, busy=1; cnt <= cnt-1.
- MUL, cnt == 0 (release cycle): all writes 1, exmem_bubble=0, busy=1; if id_mul then cnt <= MUL_LAT-1, stay MUL; else next RUN. ex_branch_taken and load_use are don't-care in MUL (EX holds the multiply).
- Flush outputs are 0 in MUL.
- stall_cycles: stat_clr -> 0 (priority); else if pc_write=0 and value != 16'hFFFF, +1; saturates at 16'hFFFF.
- reset asserted: state RUN, cnt 0, stall_cycles 0; outputs forced pc_write=0, ifid_write=0, idex_write=0, ifid_flush=1, idex_flush=1, exmem_bubble=1, busy=0.

## Timing
- Load-use costs exactly 1 bubble; on the following cycle the load is in MEM and load_use evaluates 0.
- Branch redirect: flushes effective at the edge ending the cycle ex_branch_taken is high; 2 instructions squashed.
- Multiply: ID in cycle t (RUN), in EX cycles t+1..t+MUL_LAT (MUL state), result enters EX/MEM at edge ending t+MUL_LAT. Stall penalty MUL_LAT-1 cycles.
- Back-to-back multiplies: second enters EX on the release-cycle edge, no extra gap.
- Reset deassert: first active cycle evaluates in RUN.
- stall_cycles updates on the edge ending the counted cycle; visible next cycle.

## Test plan
- Load x5 in EX, ID rs1=5: pc_write=0, ifid_write=0, idex_flush=1 one cycle; next cycle all writes 1; stall_cycles=1.
- Load to x0, ID rs1=0: no stall; ex_rd=5, id_rs2=5, id_uses_rs2=0: no stall.
- ex_branch_taken=1 with load_use=1 and id_mul=1 same cycle: ifid_flush=1, idex_flush=1, pc_write=1, state stays RUN.
- MUL_LAT=4, id_mul pulse: busy high 4 cycles, exmem_bubble high 3, pc_write low 3; second id_mul in release cycle: busy 8 consecutive cycles.
- reset asserted mid-MUL (cnt=2): busy=0 immediately, stall_cycles=0; after deassert, plain instruction flows with all writes 1.
- stall_cycles preloaded to 16'hFFFE via stalls, 3 more stall cycles -> 16'hFFFF held; stat_clr with pc_write=0 -> 0.
